// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode definitions: instruction bus widths, zero word and
// the {pc, inst} fetch entry that the predecode stage will reuse.
`ifndef IF_ID_QUEUE_DEFS
`define IF_ID_QUEUE_DEFS
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`endif

package if_id_queue_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;
  typedef logic [INST_BUS_W-1:0]      inst_t;

  // One buffered fetch slot; storage keeps pc and inst side by side.
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side bundle of the instruction buffer.
interface if_id_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32
);
  localparam int POP_W = $clog2(ISSUE_WIDTH + 1);

  logic [FETCH_WIDTH-1:0]            if_valid_i;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] if_pc_i;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] if_inst_i;
  logic                              if_ready_o;
  logic [ISSUE_WIDTH-1:0]            id_valid_o;
  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0] id_pc_o;
  logic [ISSUE_WIDTH*INST_WIDTH-1:0] id_inst_o;
  logic [POP_W-1:0]                  id_pop_num_i;

  // Buffer side.
  modport slave (
    input  if_valid_i, if_pc_i, if_inst_i, id_pop_num_i,
    output if_ready_o, id_valid_o, id_pc_o, id_inst_o
  );

  // Fetch/decode side.
  modport master (
    output if_valid_i, if_pc_i, if_inst_i, id_pop_num_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_inst_o
  );
endinterface

// File: rtl/if_id_queue_checker.sv
// Simulation checks on decode behaviour: decode may never pop more slots
// than are currently shown as valid.
module if_id_queue_checker #(
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_W       = 4,
  parameter int POP_W       = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  input logic [CNT_W-1:0] count,
  input logic [POP_W-1:0] pop_num
);

  logic [CNT_W-1:0] avail_s;

  // Number of slots decode can legally consume this cycle.
  always_comb begin
    if (count >= CNT_W'(ISSUE_WIDTH)) begin
      avail_s = CNT_W'(ISSUE_WIDTH);
    end else begin
      avail_s = count;
    end
  end

  a_pop_legal: assert property (@(posedge clk) disable iff (!rst)
    (flush || (CNT_W'(pop_num) <= avail_s)));

endmodule

// File: rtl/if_id_queue_lane_compact.sv
// Maps the fetch valid mask to dense write offsets (number of set lanes
// below each lane) and the total number of set lanes.
module if_id_queue_lane_compact #(
  parameter  int FETCH_WIDTH = 2,
  localparam int LANE_W      = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FETCH_WIDTH-1:0]             lane_valid,
  output logic [FETCH_WIDTH-1:0][LANE_W-1:0] lane_offset,
  output logic [LANE_W-1:0]                  lane_count
);

  logic [LANE_W-1:0] running_s;

  // Prefix count over the mask, lane 0 first.
  always_comb begin
    running_s   = {LANE_W{1'b0}};
    lane_offset = {(FETCH_WIDTH*LANE_W){1'b0}};
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      lane_offset[j] = running_s;
      if (lane_valid[j]) begin
        running_s = running_s + LANE_W'(1);
      end else begin
        running_s = running_s;
      end
    end
    lane_count = running_s;
  end

endmodule

// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode: circular FIFO taking up to
// FETCH_WIDTH masked instructions per cycle and showing the ISSUE_WIDTH
// oldest to decode in program order, with single-cycle flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = INST_ADDR_BUS_W,
  parameter int INST_WIDTH  = INST_BUS_W
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  if_id_queue_if.slave   bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = $clog2(FETCH_WIDTH + 1);
  localparam int POP_W  = $clog2(ISSUE_WIDTH + 1);
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - FETCH_WIDTH);
  localparam logic [CNT_W-1:0] ISSUE_MAX   = CNT_W'(ISSUE_WIDTH);

  logic [ADDR_WIDTH-1:0] mem_pc_r   [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst_r [DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;

  logic                              ready_s;
  logic                              push_s;
  logic [CNT_W-1:0]                  push_cnt_s;
  logic [CNT_W-1:0]                  avail_s;
  logic [CNT_W-1:0]                  pop_req_s;
  logic [CNT_W-1:0]                  pop_cnt_s;
  logic [FETCH_WIDTH-1:0][LANE_W-1:0] lane_offset_s;
  logic [LANE_W-1:0]                 lane_count_s;

  if_id_queue_lane_compact #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_lane_compact (
    .lane_valid  (bus.if_valid_i),
    .lane_offset (lane_offset_s),
    .lane_count  (lane_count_s)
  );

  if_id_queue_checker #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .CNT_W       (CNT_W),
    .POP_W       (POP_W)
  ) u_checker (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .count   (count_r),
    .pop_num (bus.id_pop_num_i)
  );

  // Ready from registered occupancy only, so a same-cycle pop never helps.
  always_comb begin
    ready_s        = (count_r <= READY_LIMIT);
    bus.if_ready_o = ready_s;
    push_s         = (|bus.if_valid_i) && ready_s && !flush;
    if (push_s) begin
      push_cnt_s = CNT_W'(lane_count_s);
    end else begin
      push_cnt_s = {CNT_W{1'b0}};
    end
  end

  // Clamp the decode pop request to the number of valid slots.
  always_comb begin
    pop_req_s = CNT_W'(bus.id_pop_num_i);
    if (count_r >= ISSUE_MAX) begin
      avail_s = ISSUE_MAX;
    end else begin
      avail_s = count_r;
    end
    if (pop_req_s > avail_s) begin
      pop_cnt_s = avail_s;
    end else begin
      pop_cnt_s = pop_req_s;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      head_r  <= head_r + PTR_W'(pop_cnt_s);
      tail_r  <= tail_r + PTR_W'(push_cnt_s);
      count_r <= count_r + push_cnt_s - pop_cnt_s;
    end
  end

  // Write set lanes densely at tail; storage itself is never cleared.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (push_s && bus.if_valid_i[j]) begin
        mem_pc_r[tail_r + PTR_W'(lane_offset_s[j])]   <= bus.if_pc_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        mem_inst_r[tail_r + PTR_W'(lane_offset_s[j])] <= bus.if_inst_i[j*INST_WIDTH +: INST_WIDTH];
      end
    end
  end

  // Present the oldest entries; invalid slots read as zero bubbles.
  always_comb begin
    bus.id_valid_o = {ISSUE_WIDTH{1'b0}};
    bus.id_pc_o    = {(ISSUE_WIDTH*ADDR_WIDTH){1'b0}};
    bus.id_inst_o  = {(ISSUE_WIDTH*INST_WIDTH){1'b0}};
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (count_r > CNT_W'(k)) begin
        bus.id_valid_o[k]                       = 1'b1;
        bus.id_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH] = mem_pc_r[head_r + PTR_W'(k)];
        bus.id_inst_o[k*INST_WIDTH +: INST_WIDTH] = mem_inst_r[head_r + PTR_W'(k)];
      end else begin
        bus.id_valid_o[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic, all
// checked against a queue-of-entries reference model.
module tb_if_id_queue;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int XW    = 32;
  localparam int PW    = $clog2(IW + 1);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  ent_t q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] pc_next;

  always #5 clk = ~clk;

  if_id_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .ADDR_WIDTH(AW), .INST_WIDTH(XW)) bus ();

  if_id_queue #(
    .FETCH_WIDTH (FW),
    .ISSUE_WIDTH (IW),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .INST_WIDTH  (XW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model queue.
  task automatic check_outputs(input string ctx);
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_v;
    check({ctx, ":ready"}, 64'(bus.if_ready_o), 64'((DEPTH - q.size()) >= FW));
    for (int k = 0; k < IW; k++) begin
      e_v    = (q.size() > k);
      e_pc   = e_v ? q[k].pc : 32'h0;
      e_inst = e_v ? q[k].inst : 32'h0;
      check($sformatf("%s:valid%0d", ctx, k), 64'(bus.id_valid_o[k]), 64'(e_v));
      check($sformatf("%s:pc%0d", ctx, k), 64'(bus.id_pc_o[k*AW +: AW]), 64'(e_pc));
      check($sformatf("%s:inst%0d", ctx, k), 64'(bus.id_inst_o[k*XW +: XW]), 64'(e_inst));
    end
  endtask

  // One clock of traffic; called at a falling edge, returns at the next.
  task automatic cycle(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [31:0] in0, input logic [31:0] in1, input int pop,
                       input logic fl);
    logic ready_pre;
    ent_t e;
    bus.if_valid_i   = mask;
    bus.if_pc_i      = {pc1, pc0};
    bus.if_inst_i    = {in1, in0};
    bus.id_pop_num_i = PW'(pop);
    flush            = fl;
    #1;
    check_outputs("pre");
    ready_pre = ((DEPTH - q.size()) >= FW);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      for (int i = 0; i < pop; i++) void'(q.pop_front());
      if (mask != 2'b00 && ready_pre) begin
        if (mask[0]) begin e.pc = pc0; e.inst = in0; q.push_back(e); end
        if (mask[1]) begin e.pc = pc1; e.inst = in1; q.push_back(e); end
      end
    end
    @(negedge clk);
    check_outputs("post");
  endtask

  task automatic push_pair(input int pop);
    cycle(2'b11, pc_next, pc_next + 32'd4, $urandom, $urandom, pop, 1'b0);
    pc_next = pc_next + 32'd8;
  endtask

  task automatic idle(input logic fl);
    cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, fl);
  endtask

  initial begin
    int n;
    int lim;
    bus.if_valid_i   = '0;
    bus.if_pc_i      = '0;
    bus.if_inst_i    = '0;
    bus.id_pop_num_i = '0;
    pc_next          = 32'h0000_1000;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus.id_valid_o), 64'h0);
    check("rst_pc", 64'(bus.id_pc_o), 64'h0);
    check("rst_inst", 64'(bus.id_inst_o), 64'h0);
    check("rst_ready", 64'(bus.if_ready_o), 64'h1);
    rst = 1'b1;
    @(negedge clk);

    // Single-lane push.
    cycle(2'b01, 32'h1c00_0000, 32'h0, 32'h0280_0c0c, 32'h0, 0, 1'b0);
    check("single_valid", 64'(bus.id_valid_o), 64'h1);
    check("single_pc0", 64'(bus.id_pc_o[31:0]), 64'h1c00_0000);
    check("single_inst0", 64'(bus.id_inst_o[31:0]), 64'h0280_0c0c);
    check("single_pc1", 64'(bus.id_pc_o[63:32]), 64'h0);

    // Mask hole: only lane 1 stored, lands in slot 0.
    idle(1'b1);
    cycle(2'b10, 32'h100, 32'h104, 32'h11, 32'h22, 0, 1'b0);
    check("hole_valid", 64'(bus.id_valid_o), 64'h1);
    check("hole_pc0", 64'(bus.id_pc_o[31:0]), 64'h104);

    // Fill to full, then pop two with a held group.
    idle(1'b1);
    for (int i = 0; i < 4; i++) push_pair(0);
    check("full_ready", 64'(bus.if_ready_o), 64'h0);
    check("full_valid", 64'(bus.id_valid_o), 64'h3);
    push_pair(2);
    check("after_pop_ready", 64'(bus.if_ready_o), 64'h1);

    // Steady state push 2 / pop 2 across wrap-around.
    for (int i = 0; i < 20; i++) push_pair(2);

    // Flush with push and pop in the same cycle, 5 entries buffered.
    idle(1'b1);
    push_pair(0);
    push_pair(0);
    cycle(2'b01, pc_next, 32'h0, 32'h5a5a_0001, 32'h0, 0, 1'b0);
    pc_next = pc_next + 32'd8;
    check("five_valid", 64'(bus.id_valid_o), 64'h3);
    cycle(2'b11, pc_next, pc_next + 32'd4, 32'h1, 32'h2, 2, 1'b1);
    pc_next = pc_next + 32'd8;
    check("flush_valid", 64'(bus.id_valid_o), 64'h0);
    check("flush_ready", 64'(bus.if_ready_o), 64'h1);
    repeat (3) idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      lim = (q.size() < IW) ? q.size() : IW;
      n   = $urandom_range(0, lim);
      cycle(2'($urandom_range(0, 3)), pc_next, pc_next + 32'd4, $urandom, $urandom, n,
            ($urandom_range(0, 24) == 0));
      pc_next = pc_next + 32'd8;
    end

    // Asynchronous reset mid-stream.
    idle(1'b1);
    push_pair(0);
    push_pair(0);
    bus.if_valid_i   = 2'b00;
    bus.id_pop_num_i = '0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(bus.id_valid_o), 64'h0);
    check("arst_pc", 64'(bus.id_pc_o), 64'h0);
    check("arst_inst", 64'(bus.id_inst_o), 64'h0);
    check("arst_ready", 64'(bus.if_ready_o), 64'h1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle(2'b01, 32'h200, 32'h0, 32'hdead_0200, 32'h0, 0, 1'b0);
    check("post_rst_valid", 64'(bus.id_valid_o), 64'h1);
    check("post_rst_pc0", 64'(bus.id_pc_o[31:0]), 64'h200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction buffer between fetch and decode, replacing the single-entry IF/ID pipeline register. Accepts up to FETCH_WIDTH instructions per cycle from fetch with a per-lane valid mask. Buffers them in a circular FIFO of DEPTH entries and presents up to ISSUE_WIDTH oldest instructions to decode in program order. Supports partial consumption by decode and a single-cycle flush for branch redirect or exception.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions offered by fetch per cycle
- ISSUE_WIDTH, 2, instruction slots presented to decode
- DEPTH, 8, buffer entries; power of two, ≥ FETCH_WIDTH and ≥ ISSUE_WIDTH
- ADDR_WIDTH, 32, PC width
- INST_WIDTH, 32, instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  discard all buffered and incoming instructions
- if_valid_i  in  FETCH_WIDTH  per-lane valid mask; lane 0 is oldest
- if_pc_i  in  FETCH_WIDTH*ADDR_WIDTH  per-lane PC
- if_inst_i  in  FETCH_WIDTH*INST_WIDTH  per-lane instruction
- if_ready_o  out  1  buffer can take a full fetch group this cycle
- id_valid_o  out  ISSUE_WIDTH  per-slot valid; slot 0 is oldest
- id_pc_o  out  ISSUE_WIDTH*ADDR_WIDTH  per-slot PC; zero when slot invalid
- id_inst_o  out  ISSUE_WIDTH*INST_WIDTH  per-slot instruction; zero when slot invalid
- id_pop_num_i  in  $clog2(ISSUE_WIDTH+1)  slots consumed by decode this cycle

## Operation
- State:
  - DEPTH-entry storage of {pc, inst}
  - head and tail pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH
  - count, $clog2(DEPTH+1) bits
- Push:
  - A push occurs when |if_valid_i && if_ready_o && !flush.
  - Set lanes are compacted in lane order and written at tail, tail+1, ….
  - tail and count advance by popcount(if_valid_i).
  - Mask holes are allowed, e.g. 2'b10 writes lane 1 only, at tail.
- if_ready_o = (DEPTH − count) ≥ FETCH_WIDTH.
  - Uses registered count only; a same-cycle pop does not raise ready, which keeps the path short.
  - Fetch holds its group while ready is low, as it does today with stall.
- Pop:
  - id_valid_o[k] = (count > k).
  - Slot k shows the entry at head+k, modulo DEPTH.
  - When !flush, head advances by id_pop_num_i and count decreases by id_pop_num_i.
  - Decode must consume in order; id_pop_num_i > number of valid slots is illegal. It is asserted in simulation and clamped to the valid count in RTL.
- Simultaneous push and pop: count_next = count + pushed − popped. Never exceeds DEPTH, because of the ready rule.
- Flush:
  - head, tail and count clear to 0 on the next edge.
  - Same-cycle push and pop are ignored.
  - Flush has priority over everything except reset.
- Empty buffer: all id_valid_o low and all id_pc_o / id_inst_o zero. These are bubbles, matching the existing zero-NOP convention.
- Storage is not cleared on flush; only pointers and count are cleared.

## Timing
- Reset (async assert, sync release):
  - head = tail = count = 0
  - id_valid_o = 0, id_pc_o = 0, id_inst_o = 0
  - if_ready_o = 1
- Latency:
  - An instruction pushed at edge N is visible on id_* after edge N. This is one cycle, the same as the old register.
  - There is no combinational path from if_* to id_*.
- Outputs are combinational from registered storage and pointers only.
  - id_pop_num_i does not affect same-cycle outputs.
  - if_ready_o depends only on count.
- Wrap-around: pointer arithmetic is modulo DEPTH. Reads of head+k and writes of tail+j wrap transparently.
- Full: count == DEPTH gives if_ready_o = 0. A pop in that cycle raises ready one cycle later.
- Flush in cycle N: id_valid_o = 0 and if_ready_o = 1 from cycle N+1.
- Reset asserted mid-operation: all state clears immediately (asynchronous); contents are lost.

## Structure
- Shared header/package holds:
  - `InstAddrBus, `InstBus, `ZeroWord
  - a fetch-entry typedef/macro {pc, inst}, reused by the future predecode stage
- Sub-module lane_compact:
  - combinational; maps FETCH_WIDTH masked lanes to dense write offsets and a popcount
  - instantiated once

## Test plan
- Reset then single-lane push (mask 01, pc 0x1c000000, inst 0x02800c0c) → next cycle id_valid_o = 01, slot 0 shows those values; slot 1 zero.
- Four full pushes with no pops (DEPTH 8, FETCH_WIDTH 2) → count 8, if_ready_o = 0. Next, pop 2 → ready = 1 one cycle later; order preserved.
- Mask 10 with pc lanes {0x100, 0x104} → only 0x104 stored, in slot 0.
- Steady state: push 2 and pop 2 every cycle for 20 cycles across wrap-around → PCs emerge strictly in order with no loss or duplication.
- Push, pop and flush in the same cycle with 5 entries → next cycle count 0, id_valid_o = 0, if_ready_o = 1; no pushed entry appears later.
- rst asserted mid-stream → outputs zero immediately. After release, a push of pc 0x200 appears alone in slot 0.
